dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipelined RV32I core: the far end of the fetch/stall
//  handshake whose dmem_valid the program counter waits on during loads.
//  Accepts one load/store request at a time, inserts WAIT_CYCLES wait states, and
//  pulses dmem_valid for one cycle when the access completes.
//  Sits between the MEM stage and a synchronous word-organised data RAM held inside the block.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words in the RAM (power of two)
//  ADDR_W       10    word-index width; must equal log2(DEPTH_WORDS)
//  WAIT_CYCLES  2     wait states between acceptance and response (0..15)
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   asynchronous reset, active-high
//  dmem_req    in   1   request strobe from MEM stage
//  dmem_we     in   1   1 = store, 0 = load
//  dmem_addr   in   32  byte address; word index = dmem_addr[ADDR_W+1:2]; [1:0] ignored
//  dmem_wdata  in   32  store data, lane-aligned
//  dmem_wmask  in   4   byte-lane enables for stores (bit i -> wdata[8i+7:8i])
//  dmem_ready  out  1   high when a request can be accepted (state IDLE)
//  dmem_valid  out  1   one-cycle completion pulse
//  dmem_rdata  out  32  load data, valid while dmem_valid=1
//  dmem_err    out  1   out-of-range flag (DMEM_RANGE_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: state=IDLE, dmem_valid=0, dmem_rdata=0, dmem_err=0, dmem_ready=1, counter=0.
//    RAM contents are NOT cleared by reset.
//  - Acceptance: rising edge with dmem_req=1 and dmem_ready=1 (edge k); addr/we/wdata/wmask latched.
//  - States: IDLE -> (accept) -> WAIT if WAIT_CYCLES>0, else RESP; WAIT counts WAIT_CYCLES-1
//    down to 0, then RESP; RESP -> IDLE unconditionally after one cycle.
//  - Latency: RAM access commits at edge k+WAIT_CYCLES; dmem_valid is high for exactly
//    the one cycle following that edge. Throughput: one access per WAIT_CYCLES+2 cycles.
//  - Load: dmem_rdata = RAM[word index] sampled at commit edge; held until next response.
//  - Store: only lanes with wmask bit set are written at commit edge; wmask=0 is a legal
//    no-op store; dmem_rdata=0 on store responses.
//  - dmem_req while ready=0 (WAIT/RESP) is ignored; requester must hold or re-issue.
//  - Input changes after acceptance have no effect on the in-flight access.
//  - Reset asserted before commit edge aborts the access: no RAM write, no valid pulse.
//  - Reset asserted during RESP cycle drops dmem_valid immediately (async).
//  - Word index wraps: addresses beyond DEPTH_WORDS alias modulo DEPTH_WORDS (no range check).
// CONFIGURATION
//  DMEM_RANGE_CHECK_EN defined: dmem_addr[31:2] >= DEPTH_WORDS is out of range; the access
//    keeps normal timing, but a store writes nothing, a load returns 0, and dmem_err=1
//    alongside dmem_valid (same single cycle); dmem_err=0 otherwise.
//  DMEM_RANGE_CHECK_EN undefined: no check, address aliasing as above, dmem_err tied 0.
// TESTING
//  1 WAIT_CYCLES=2: store 0xDEADBEEF mask 4'hF @0x10 accepted edge k -> valid high after
//    edge k+2 for 1 cycle; load @0x10 -> rdata=0xDEADBEEF, ready low for 3 cycles.
//  2 Byte lanes: word @0x20=0x11223344, store 0xAABBCCDD mask 4'b0101 -> load 0x11BB33DD.
//  3 Busy: second req asserted during WAIT -> ignored, exactly one valid pulse;
//    WAIT_CYCLES=0 back-to-back loads -> valid every 2nd cycle.
//  4 Reset one cycle before commit of store 0x55 @0x30 -> no valid, word @0x30 unchanged,
//    ready=1 immediately after reset.
//  5 Range: DEPTH_WORDS=1024, load @0x1000 -> with macro: valid+err, rdata=0;
//    without: rdata = word @0x0000, err=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bundle between the MEM stage (master) and the data-memory
//   responder (slave).
//   Ports (all signals, no interface ports):
//     dmem_req, dmem_we, dmem_addr[31:0], dmem_wdata[31:0], dmem_wmask[3:0]
//         master -> slave request fields
//     dmem_ready, dmem_valid, dmem_rdata[31:0], dmem_err
//         slave -> master status and response fields
interface dmem_responder_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wmask,
        input  dmem_ready,
        input  dmem_valid,
        input  dmem_rdata,
        input  dmem_err
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wmask,
        output dmem_ready,
        output dmem_valid,
        output dmem_rdata,
        output dmem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the pipelined RV32I core. Accepts one load/store
//   at a time, waits WAIT_CYCLES cycles, commits the access to an internal
//   word-organised RAM and pulses dmem_valid for one cycle.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous reset, active-high (RAM contents are kept)
//     bus  - dmem_responder_if.slave (request in, ready/valid/rdata/err out)
//   Optional build macro:
//     DMEM_RANGE_CHECK_EN - flag word indices >= DEPTH_WORDS as out of range
//                           (no write, rdata 0, dmem_err with dmem_valid).
//                           Undefined: addresses alias modulo DEPTH_WORDS and
//                           dmem_err is tied low.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | ready for a request; acceptance latches the request fields
//   WAIT   | counting wait states down to 0; commit on the cnt==0 edge
//   RESP   | dmem_valid high for exactly this cycle, then back to IDLE
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam bit         NO_WAIT     = (WAIT_CYCLES == 0);
    localparam int         WAIT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] WAIT_INIT   = WAIT_INIT_I[3:0];

    logic [1:0]  state;
    logic [3:0]  cnt;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        commit;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wmask;
    logic [ADDR_W-1:0] c_idx;
    logic        c_oor;

    logic [31:0] mem [DEPTH_WORDS];

    // Gating with rst keeps a request that is present while reset is held
    // from being accepted (and, with no wait states, committed) at that edge.
    assign accept = bus.dmem_req && (state == S_IDLE) && !rst;

    // With no wait states the access commits on the acceptance edge itself,
    // so the live request fields are used; otherwise the latched copy is.
    always_comb begin
        commit  = 1'b0;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_wmask = wmask_q;
        if (NO_WAIT) begin
            commit  = accept;
            c_we    = bus.dmem_we;
            c_addr  = bus.dmem_addr;
            c_wdata = bus.dmem_wdata;
            c_wmask = bus.dmem_wmask;
        end else begin
            commit  = (state == S_WAIT) && (cnt == 4'd0);
        end
    end

    assign c_idx = c_addr[ADDR_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    assign c_oor = (c_addr[31:2] >= 30'(DEPTH_WORDS));
`else
    assign c_oor = 1'b0;
`endif

    // Byte offset and (without range check) upper address bits do not
    // affect the access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{c_addr[31:ADDR_W+2], c_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= bus.dmem_we;
                        addr_q  <= bus.dmem_addr;
                        wdata_q <= bus.dmem_wdata;
                        wmask_q <= bus.dmem_wmask;
                        if (NO_WAIT) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Response data is captured at the commit edge and held until the next
    // response; stores and out-of-range accesses return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (commit) begin
            rdata_q <= (c_we || c_oor) ? 32'd0 : mem[c_idx];
            err_q   <= c_oor;
        end
    end

    // RAM has no reset: contents survive rst by design.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wmask[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.dmem_ready = (state == S_IDLE);
    assign bus.dmem_valid = (state == S_RESP);
    assign bus.dmem_rdata = rdata_q;
    assign bus.dmem_err   = (state == S_RESP) && err_q;

endmodule
